// File: rtl/fp_pkg.sv
// Shared fp32 types, constants and the IEEE-754 special-case classifier used at the issue stage.
// Pure types/functions; no timing or flow control of its own.
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic  op;
    fp32_t a;
    fp32_t b;
  } fp_req_t;

  typedef struct packed {
    logic  special;
    fp32_t result;
  } fp_spec_t;

  // Exponent 0 counts as signed zero, so denormals are flushed before fp_12 ever sees them.
  function automatic fp_spec_t fp_classify(fp_req_t req);
    fp_spec_t r;
    logic     b_sign;
    logic     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    b_sign = req.b.sign ^ req.op;
    a_nan  = (req.a.exp == FP_EXP_MAX) && (req.a.mant != '0);
    b_nan  = (req.b.exp == FP_EXP_MAX) && (req.b.mant != '0);
    a_inf  = (req.a.exp == FP_EXP_MAX) && (req.a.mant == '0);
    b_inf  = (req.b.exp == FP_EXP_MAX) && (req.b.mant == '0);
    a_zero = (req.a.exp == 8'h00);
    b_zero = (req.b.exp == 8'h00);
    r.special = 1'b1;
    r.result  = FP_QNAN;
    if (a_nan || b_nan) begin
      r.result = FP_QNAN;
    end else if (a_inf && b_inf) begin
      r.result = (req.a.sign != b_sign) ? FP_QNAN : {req.a.sign, FP_EXP_MAX, 23'd0};
    end else if (a_inf) begin
      r.result = {req.a.sign, FP_EXP_MAX, 23'd0};
    end else if (b_inf) begin
      r.result = {b_sign, FP_EXP_MAX, 23'd0};
    end else if (a_zero && b_zero) begin
      r.result = {req.a.sign & b_sign, 31'd0};
    end else if (a_zero) begin
      r.result = {b_sign, req.b.exp, req.b.mant};
    end else if (b_zero) begin
      r.result = req.a;
    end else begin
      r.special = 1'b0;
      r.result  = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Request FIFO holding {op, a, b, tag}; head visible combinationally, zero-cycle read.
// Push ignored when full, pop ignored when empty; simultaneous push/pop both honoured.
module fp_req_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fp_req_t          push_req,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output fp_req_t          head_req,
  output logic [TAG_W-1:0] head_tag
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    fp_req_t          req;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_req = mem_q[rd_ptr_q[AW-1:0]].req;
  assign head_tag = mem_q[rd_ptr_q[AW-1:0]].tag;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{req: push_req, tag: push_tag};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue stage for fp_12: FIFO -> S1 (drives fp_12) -> S2 result reg; 2 edges accept-to-out_valid.
// in_ready = !fifo_full; S1/S2 hold on out_ready low, fp_* stable while stalled.
module fp_addsub_issue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             fp_op,
  output logic [31:0]      fp_a,
  output logic [31:0]      fp_b,
  input  logic [31:0]      fp_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_special
);

  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  fp_req_t          push_req, head_req;
  logic [TAG_W-1:0] head_tag;
  fp_spec_t         head_spec;
  logic             s1_load, s2_load;

  logic             s1_valid_q, s1_valid_d;
  logic             fp_op_q, fp_op_d;
  fp32_t            fp_a_q, fp_a_d;
  fp32_t            fp_b_q, fp_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  fp_spec_t         s1_spec_q, s1_spec_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_special_q, out_special_d;

  assign push_req  = {in_op, in_a, in_b};
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = s1_load;

  fp_req_fifo #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (push_req),
    .push_tag (in_tag),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_req (head_req),
    .head_tag (head_tag)
  );

  assign head_spec = fp_classify(head_req);

  assign s2_load = (!out_valid_q || out_ready) && s1_valid_q;
  assign s1_load = (!s1_valid_q || s2_load) && !fifo_empty;

  always_comb begin
    s1_valid_d = s1_valid_q;
    fp_op_d    = fp_op_q;
    fp_a_d     = fp_a_q;
    fp_b_d     = fp_b_q;
    s1_tag_d   = s1_tag_q;
    s1_spec_d  = s1_spec_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      fp_op_d    = head_req.op;
      fp_a_d     = head_req.a;
      fp_b_d     = head_req.b;
      s1_tag_d   = head_tag;
      s1_spec_d  = head_spec;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // fp_c is only trusted when S1 did not already resolve the result itself.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;
    out_special_d = out_special_q;
    if (s2_load) begin
      out_valid_d   = 1'b1;
      out_result_d  = s1_spec_q.special ? s1_spec_q.result : fp_c;
      out_tag_d     = s1_tag_q;
      out_special_d = s1_spec_q.special;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      fp_op_q       <= 1'b0;
      fp_a_q        <= '0;
      fp_b_q        <= '0;
      s1_tag_q      <= '0;
      s1_spec_q     <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_special_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      fp_op_q       <= fp_op_d;
      fp_a_q        <= fp_a_d;
      fp_b_q        <= fp_b_d;
      s1_tag_q      <= s1_tag_d;
      s1_spec_q     <= s1_spec_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_special_q <= out_special_d;
    end
  end

  assign fp_op       = fp_op_q;
  assign fp_a        = fp_a_q;
  assign fp_b        = fp_b_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_special = out_special_q;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Bench for fp_addsub_issue: models fp_12 with real arithmetic and scoreboards every result.
module tb_fp_addsub_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_op;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             fp_op;
  logic [31:0]      fp_a, fp_b, fp_c;
  logic             out_valid, out_ready, out_special;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             spec;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_addsub_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b), .fp_c(fp_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_special(out_special)
  );

  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h00) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] from_real(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Stand-in for the combinational fp_12 datapath (truncating).
  function automatic logic [31:0] fp12(input logic op, input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = to_real(a);
    rb = to_real(b);
    return from_real(op ? (ra - rb) : (ra + rb));
  endfunction

  always_comb fp_c = fp12(fp_op, fp_a, fp_b);

  function automatic logic [32:0] exp_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic sa, sbe, an, bn, ai, bi, az, bz;
    sa  = a[31];
    sbe = b[31] ^ op;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    az  = (a[30:23] == 8'h00);
    bz  = (b[30:23] == 8'h00);
    if (an || bn) return {1'b1, 32'h7FC0_0000};
    if (ai && bi) return (sa != sbe) ? {1'b1, 32'h7FC0_0000} : {1'b1, sa, 8'hFF, 23'd0};
    if (ai) return {1'b1, sa, 8'hFF, 23'd0};
    if (bi) return {1'b1, sbe, 8'hFF, 23'd0};
    if (az && bz) return {1'b1, sa & sbe, 31'd0};
    if (az) return {1'b1, sbe, b[30:0]};
    if (bz) return {1'b1, a};
    return {1'b0, fp12(op, a, b)};
  endfunction

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_any();
    logic       s;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, m | 23'd1};
      3:       return {s, 8'h00, m};
      default: return rnd_norm();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Consumption happens at the posedge following this negedge sample.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (scb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_output observed=tag %0d expected=no output", out_tag);
      end
      if (scb.size() != 0) begin
        exp_t e;
        e = scb.pop_front();
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("out_result", out_result, e.res);
        chk("out_special", 32'(out_special), 32'(e.spec));
      end
    end
  end

  task automatic send_exp(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic spec);
    exp_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.tag = tag; e.res = res; e.spec = spec;
        scb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $error("FAIL send_timeout tag=%0d observed=not accepted expected=accepted", tag);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    logic [32:0] m;
    m = exp_model(op, a, b);
    send_exp(op, a, b, tag, m[31:0], m[32]);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (scb.size() == 0) return;
      @(posedge clk); #1;
    end
    checks++; failures++;
    $error("FAIL drain_timeout observed=%0d pending expected=0 pending", scb.size());
    scb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic        d_op   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] d_a    [7] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0001,
                              32'hFF80_0000, 32'h0000_0001, 32'h4040_0000};
  logic [31:0] d_b    [7] = '{32'hC000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000,
                              32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
  logic [31:0] d_res  [7] = '{32'hC000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                              32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000};
  logic        d_spec [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [31:0] bp_a [8];
    logic [31:0] bp_b [8];
    logic [31:0] held_a, held_res;
    int          acc;

    rst = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #10;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fp_a", fp_a, 32'd0);
    chk("rst_fp_op", 32'(fp_op), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Smoke: 1.0 + 2.0, checking each stage of the two-edge latency.
    send_exp(1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd1, 32'h4040_0000, 1'b0);
    chk("smoke_valid_n", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("smoke_fp_a", fp_a, 32'h3F80_0000);
    chk("smoke_fp_b", fp_b, 32'h4000_0000);
    chk("smoke_valid_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("smoke_valid_n2", 32'(out_valid), 32'd1);
    chk("smoke_result", out_result, 32'h4040_0000);
    chk("smoke_special", 32'(out_special), 32'd0);
    drain();

    // Signed zeros, Inf/NaN, denormal flush, plain subtract.
    for (int i = 0; i < 7; i++) begin
      send_exp(d_op[i], d_a[i], d_b[i], 4'(i + 2), d_res[i], d_spec[i]);
    end
    drain();

    // Backpressure: out_ready low, offer 8 requests.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = rnd_norm();
      bp_b[i] = rnd_norm();
    end
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 8) begin
        in_valid = 1'b1; in_op = 1'b0; in_a = bp_a[acc]; in_b = bp_b[acc]; in_tag = 4'(acc);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        logic [32:0] m;
        exp_t        e;
        m = exp_model(1'b0, bp_a[acc], bp_b[acc]);
        e.tag = 4'(acc); e.res = m[31:0]; e.spec = m[32];
        scb.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'(DEPTH + 2));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    held_a   = fp_a;
    held_res = out_result;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_fp_a_stable", fp_a, held_a);
    chk("bp_fp_a_tag1", fp_a, bp_a[1]);
    chk("bp_result_stable", out_result, held_res);
    chk("bp_out_tag_held", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_release_valid", 32'(out_valid), 32'd1);
      chk("bp_release_tag", 32'(out_tag), 32'(k));
    end
    drain();

    // Wrap: 3*DEPTH back-to-back mixed requests against random out_ready.
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          send(1'($urandom_range(0, 1)), rnd_any(), rnd_any(), 4'(i));
        end
      end
      begin
        for (int j = 0; j < 80; j++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with FIFO at 3 entries and both stages occupied.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, rnd_norm(), rnd_norm(), 4'(i + 8));
    end
    @(posedge clk); #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_out_tag", 32'(out_tag), 32'd8);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_fp_a", fp_a, 32'd0);
    scb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_exp(1'b0, 32'h3F80_0000, 32'h3F80_0000, 4'd15, 32'h4000_0000, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_valid_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_valid_n2", 32'(out_valid), 32'd1);
    chk("post_rst_tag", 32'(out_tag), 32'd15);
    drain();
    chk("final_scb_empty", 32'(scb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
